// File: rtl/envelope_adsr.sv
// ADSR envelope shaper: scales a signed tone sample by an 8-bit envelope level on each step tick.
// Optional macro ENVELOPE_ROUND_EN rounds the scaled sample half up instead of truncating.
module envelope_adsr #(
  parameter logic [7:0] ATTACK_STEP   = 8'd8,
  parameter logic [7:0] DECAY_STEP    = 8'd4,
  parameter logic [7:0] SUSTAIN_LEVEL = 8'd160,
  parameter logic [7:0] RELEASE_STEP  = 8'd2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              step_in,
  input  logic              gate_in,
  input  logic signed [7:0] amp_in,
  output logic signed [7:0] amp_out,
  output logic              valid_out,
  output logic              busy_out
);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         env_q, env_d;
  logic signed [7:0]  amp_q, amp_d;
  logic               valid_q;
  logic               busy_q;
  logic [8:0]         attackSum;
  logic signed [16:0] product;

  assign attackSum = {1'b0, env_q} + {1'b0, ATTACK_STEP};

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    unique case (state_q)
      IDLE: begin
        env_d = 8'd0;
        if (gate_in) state_d = ATTACK;
      end
      ATTACK: begin
        if (!gate_in) begin
          state_d = RELEASE;
        end else if (attackSum >= 9'd255) begin
          env_d   = 8'd255;
          state_d = DECAY;
        end else begin
          env_d = attackSum[7:0];
        end
      end
      DECAY: begin
        if (!gate_in) begin
          state_d = RELEASE;
        end else if ({1'b0, env_q} > {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP}) begin
          env_d = env_q - DECAY_STEP;
        end else begin
          env_d   = SUSTAIN_LEVEL;
          state_d = SUSTAIN;
        end
      end
      SUSTAIN: begin
        if (!gate_in) state_d = RELEASE;
        else          env_d   = SUSTAIN_LEVEL;
      end
      RELEASE: begin
        if (gate_in) begin
          state_d = ATTACK;
        end else if (env_q > RELEASE_STEP) begin
          env_d = env_q - RELEASE_STEP;
        end else begin
          env_d   = 8'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        env_d   = 8'd0;
      end
    endcase
  end

  // The sample is scaled by the level held before this step's envelope update.
  always_comb begin
    product = 17'(amp_in) * 17'($signed({1'b0, env_q}));
`ifdef ENVELOPE_ROUND_EN
    product = product + 17'sd128;
`endif
    amp_d = 8'(product >>> 8);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      env_q   <= 8'd0;
      amp_q   <= 8'sd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= step_in;
      if (step_in) begin
        state_q <= state_d;
        env_q   <= env_d;
        amp_q   <= amp_d;
        busy_q  <= (state_d != IDLE);
      end
    end
  end

  assign amp_out   = amp_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_envelope_adsr.sv
// Bench for envelope_adsr: random tone samples against an arithmetic envelope model.
// Build with ENVELOPE_ROUND_EN defined to check the rounding variant.
module tb_envelope_adsr;

  localparam int AttackStep   = 8;
  localparam int DecayStep    = 4;
  localparam int SustainLevel = 160;
  localparam int ReleaseStep  = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              step_in = 1'b0;
  logic              gate_in = 1'b0;
  logic signed [7:0] amp_in = 8'sd0;
  logic signed [7:0] amp_out;
  logic              valid_out;
  logic              busy_out;

  int total = 0;
  int bad   = 0;

  // Model: envelope level plus phase name; phase 0 idle,1 attack,2 decay,3 sustain,4 release.
  int                m_env = 0;
  int                m_ph  = 0;
  logic signed [7:0] exp_amp;
  logic              exp_busy;

  envelope_adsr dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .step_in  (step_in),
    .gate_in  (gate_in),
    .amp_in   (amp_in),
    .amp_out  (amp_out),
    .valid_out(valid_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic int scaleSample(input int a, input int e);
    int p;
    p = a * e;
`ifdef ENVELOPE_ROUND_EN
    p = p + 128;
`endif
    if (p < 0) return -((-p + 255) / 256);
    return p / 256;
  endfunction

  task automatic model_step(input bit g, input int a);
    exp_amp = 8'(scaleSample(a, m_env));
    case (m_ph)
      0: if (g) m_ph = 1;
      1: if (!g) m_ph = 4;
         else begin
           m_env = (m_env + AttackStep > 255) ? 255 : m_env + AttackStep;
           if (m_env == 255) m_ph = 2;
         end
      2: if (!g) m_ph = 4;
         else begin
           m_env = (m_env - DecayStep < SustainLevel) ? SustainLevel : m_env - DecayStep;
           if (m_env == SustainLevel) m_ph = 3;
         end
      3: if (!g) m_ph = 4; else m_env = SustainLevel;
      default: if (g) m_ph = 1;
         else begin
           m_env = (m_env - ReleaseStep < 0) ? 0 : m_env - ReleaseStep;
           if (m_env == 0) m_ph = 0;
         end
    endcase
    exp_busy = (m_ph != 0);
  endtask

  // Called at a falling edge; leaves step_in high so callers can chain back-to-back steps.
  task automatic do_step(input bit g, input int a);
    gate_in = g;
    amp_in  = 8'(a);
    step_in = 1'b1;
    model_step(g, a);
    @(negedge clk_in);
  endtask

  function automatic int randAmp();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic test_reset();
    #1 rst_in = 1'b0;
    #2;
    total++;
    if (amp_out !== 8'sd0 || valid_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got amp=%0d valid=%b busy=%b want 0/0/0", amp_out, valid_out, busy_out);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    m_env = 0;
    m_ph  = 0;
    @(negedge clk_in);
  endtask

  task automatic runSequence(input string name, input int nGate1, input int nGate0, input int nGate1b);
    int a;
    bit g;
    for (int i = 0; i < nGate1 + nGate0 + nGate1b; i++) begin
      g = (i < nGate1) || (i >= nGate1 + nGate0);
      a = randAmp();
      if (name == "full" && i == 3)  a = -8;
      if (name == "full" && i == 33) a = 127;
      if (name == "full" && i == 77) a = -128;
      if (name == "retrig" && i == nGate1 + nGate0 + 2) a = -128;
      do_step(g, a);
      step_in = 1'b0;
      total++;
      if (amp_out !== exp_amp || valid_out !== 1'b1 || busy_out !== exp_busy) begin
        bad++;
        $display("[TB] FAIL %s_step%0d: got amp=%0d valid=%b busy=%b want amp=%0d valid=1 busy=%b",
                 name, i, amp_out, valid_out, busy_out, exp_amp, exp_busy);
      end
      @(negedge clk_in);
      total++;
      if (valid_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s_gap%0d: got valid=%b want 0", name, i, valid_out);
      end
      repeat (2) @(negedge clk_in);
    end
  endtask

  task automatic test_full_envelope();
    runSequence("full", 60, 81, 0);
    total++;
    if (busy_out !== 1'b0 || m_ph != 0) begin
      bad++;
      $display("[TB] FAIL full_end_idle: got busy=%b want 0", busy_out);
    end
  endtask

  task automatic test_retrigger();
    runSequence("retrig", 60, 31, 3);
  endtask

  task automatic test_reset_mid();
    runSequence("premid", 40, 0, 0);
    #1 rst_in = 1'b0;
    #1;
    total++;
    if (amp_out !== 8'sd0 || valid_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got amp=%0d valid=%b busy=%b want 0/0/0", amp_out, valid_out, busy_out);
    end
    #1 rst_in = 1'b1;
    m_env = 0;
    m_ph  = 0;
    @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      do_step(1'b0, -128);
      step_in = 1'b0;
      total++;
      if (amp_out !== exp_amp || valid_out !== 1'b1 || busy_out !== 1'b0) begin
        bad++;
        $display("[TB] FAIL post_reset_idle%0d: got amp=%0d valid=%b busy=%b want amp=%0d valid=1 busy=0",
                 i, amp_out, valid_out, busy_out, exp_amp);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_back_to_back();
    do_step(1'b1, randAmp());
    step_in = 1'b0;
    @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      do_step(1'b1, randAmp());
      total++;
      if (amp_out !== exp_amp || valid_out !== 1'b1 || busy_out !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_pulse%0d: got amp=%0d valid=%b busy=%b want amp=%0d valid=1 busy=1",
                 i, amp_out, valid_out, busy_out, exp_amp);
      end
    end
    step_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_after: got valid=%b want 0", valid_out);
    end
    do_step(1'b1, -128);
    step_in = 1'b0;
    total++;
    if (amp_out !== exp_amp || m_env != 32) begin
      bad++;
      $display("[TB] FAIL b2b_level: got amp=%0d want %0d", amp_out, exp_amp);
    end
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_full_envelope();
    test_retrigger();
    test_reset_mid();
    test_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
